// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive peripheral: receive
//                FSM state encoding, register addresses and status bit
//                positions, plus the bit-period helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam logic [3:0] UART_RX_DATA_ADDR = 4'd0;
    localparam logic [3:0] UART_RX_STAT_ADDR = 4'd1;

    localparam int UART_RX_STAT_VALID = 0;
    localparam int UART_RX_STAT_FULL  = 1;
    localparam int UART_RX_STAT_OVR   = 2;
    localparam int UART_RX_STAT_FERR  = 3;

    // Clock cycles per bit, rounded to nearest.
    function automatic int bit_cycles(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 8N1 serial receive engine. Synchronises RX, finds the start
//                edge, samples each bit at its middle and reports a complete
//                byte or a framing error with single-cycle strobes.
//  Ports       : CLK, RSTb      - clock, async active-low reset
//                i_rx           - raw serial input (asynchronous)
//                o_byte         - assembled byte, valid with o_byte_stb
//                o_byte_stb     - 1-cycle: good stop bit sampled
//                o_ferr_stb     - 1-cycle: stop bit sampled low
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       CLK,
    input  logic       RSTb,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_stb,
    output logic       o_ferr_stb
);
    import uart_pkg::*;

    localparam int          c_BIT_CYC   = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int          c_HALF_CYC  = c_BIT_CYC / 2;
    localparam logic [15:0] c_BIT_LAST  = 16'(c_BIT_CYC - 1);
    localparam logic [15:0] c_HALF_LAST = 16'(c_HALF_CYC - 1);

    logic        r_rx_meta;
    logic        r_rx_s;
    rx_state_t   r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_data, w_data_nxt;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        o_byte_stb  = 1'b0;
        o_ferr_stb  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!r_rx_s) w_state_nxt = ST_START;
            end
            ST_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt         = '0;
                    w_data_nxt[r_idx] = r_rx_s;
                    w_idx_nxt         = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        o_byte_stb  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        o_ferr_stb  = 1'b1;
                        w_state_nxt = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) yields one error, not one per frame time.
                w_cnt_nxt = '0;
                if (r_rx_s) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_byte = r_data;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : Memory-mapped 8N1 UART receive peripheral. Buffers received
//                bytes and exposes data plus sticky status on the CPU bus.
//                Build option UART_RX_FIFO_EN: when defined the buffer is a
//                FIFO_DEPTH-entry circular FIFO, otherwise a single holding
//                register.
//  Ports       : CLK, RSTb            - clock, async active-low reset
//                ADDRESS / DATA_OUT   - read select / combinational read data
//                                       (0: data head, 1: status)
//                RD                   - read strobe, pops at ADDRESS 0
//                WR_ADDRESS / DATA_IN / WR - status write-1-to-clear at 1
//                RX                   - serial input, idles high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int BITS       = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            CLK,
    input  logic            RSTb,
    input  logic [3:0]      ADDRESS,
    input  logic [3:0]      WR_ADDRESS,
    input  logic [BITS-1:0] DATA_IN,
    output logic [BITS-1:0] DATA_OUT,
    input  logic            WR,
    input  logic            RD,
    input  logic            RX
);
    import uart_pkg::*;

    logic [7:0] w_rx_byte;
    logic       w_byte_stb;
    logic       w_ferr_stb;
    logic       w_valid;
    logic       w_full;
    logic       w_pop;
    logic       w_push_ok;
    logic [7:0] w_head;
    logic       w_pop_req;
    logic       w_wr_stat;
    logic       r_ovr;
    logic       r_ferr;
    logic       w_unused_data;

    uart_rx_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_core (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .i_rx       (RX),
        .o_byte     (w_rx_byte),
        .o_byte_stb (w_byte_stb),
        .o_ferr_stb (w_ferr_stb)
    );

    assign w_pop_req = RD && (ADDRESS == UART_RX_DATA_ADDR);
    assign w_pop     = w_pop_req && w_valid;
    // The pop is applied first, so a full buffer popped this cycle has room.
    assign w_push_ok = w_byte_stb && (!w_full || w_pop);

`ifdef UART_RX_FIFO_EN
    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_head  = r_mem[r_rptr];

    // When full with a concurrent pop, wptr equals rptr: the outgoing head
    // is still read combinationally this cycle before being overwritten.
    always_ff @(posedge CLK) begin
        if (w_push_ok) r_mem[r_wptr] <= w_rx_byte;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    localparam int c_unused_depth = FIFO_DEPTH;

    logic [7:0] r_hold;
    logic       r_full;

    assign w_valid = r_full;
    assign w_full  = r_full;
    assign w_head  = r_hold;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (w_push_ok) begin
            r_hold <= w_rx_byte;
            r_full <= 1'b1;
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end
`endif

    // Sticky flags: a hardware set in the same cycle as a clear wins.
    assign w_wr_stat = WR && (WR_ADDRESS == UART_RX_STAT_ADDR);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= (w_byte_stb && w_full && !w_pop) ||
                      (r_ovr && !(w_wr_stat && DATA_IN[UART_RX_STAT_OVR]));
            r_ferr <= w_ferr_stb ||
                      (r_ferr && !(w_wr_stat && DATA_IN[UART_RX_STAT_FERR]));
        end
    end

    always_comb begin
        DATA_OUT = '0;
        case (ADDRESS)
            UART_RX_DATA_ADDR: begin
                if (w_valid) DATA_OUT[7:0] = w_head;
            end
            UART_RX_STAT_ADDR: begin
                DATA_OUT[UART_RX_STAT_VALID] = w_valid;
                DATA_OUT[UART_RX_STAT_FULL]  = w_full;
                DATA_OUT[UART_RX_STAT_OVR]   = r_ovr;
                DATA_OUT[UART_RX_STAT_FERR]  = r_ferr;
            end
            default: ;
        endcase
    end

    assign w_unused_data = ^{DATA_IN[BITS-1:4], DATA_IN[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver. Drives 8N1 frames on
//                RX and compares register reads with a queue-based model of
//                the receive buffer and sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int BIT_CYC = 104;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic [3:0]  ADDRESS = 4'd0;
    logic [3:0]  WR_ADDRESS = 4'd0;
    logic [15:0] DATA_IN = 16'd0;
    logic [15:0] DATA_OUT;
    logic        WR = 1'b0;
    logic        RD = 1'b0;
    logic        RX = 1'b1;

    uart_receiver #(
        .CLK_FREQ   (12000000),
        .BAUD_RATE  (115200),
        .BITS       (16),
        .FIFO_DEPTH (8)
    ) dut (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .ADDRESS    (ADDRESS),
        .WR_ADDRESS (WR_ADDRESS),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (DATA_OUT),
        .WR         (WR),
        .RD         (RD),
        .RX         (RX)
    );

    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q[$];
    bit         m_ovr   = 1'b0;
    bit         m_ferr  = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_status();
        return {12'd0, m_ferr, m_ovr, (q.size() == DEPTH), (q.size() != 0)};
    endfunction

    function automatic logic [15:0] exp_head();
        return (q.size() != 0) ? {8'd0, q[0]} : 16'd0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            RX = frame[i];
            repeat (BIT_CYC) @(negedge CLK);
        end
    endtask

    // Sends one frame; a bad stop bit is held low for stop_len bit periods.
    task automatic send(input logic [7:0] d, input bit stop_ok, input int stop_len);
        drive_bits({stop_ok, d, 1'b0}, 10);
        if (!stop_ok && stop_len > 1) repeat ((stop_len - 1) * BIT_CYC) @(negedge CLK);
        RX = 1'b1;
        idle(4);
        if (stop_ok) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic check_status(input string tag);
        logic [15:0] v;
        @(negedge CLK);
        ADDRESS = 4'd1;
        #1 v = DATA_OUT;
        check({tag, "_stat"}, v, exp_status());
        ADDRESS = 4'd0;
        #1 v = DATA_OUT;
        check({tag, "_data"}, v, exp_head());
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] v;
        logic [7:0]  dropped;
        @(negedge CLK);
        ADDRESS = 4'd0;
        RD = 1'b1;
        #1 v = DATA_OUT;
        check(tag, v, exp_head());
        @(negedge CLK);
        RD = 1'b0;
        if (q.size() != 0) dropped = q.pop_front();
    endtask

    task automatic write_stat(input logic [3:0] v);
        @(negedge CLK);
        WR_ADDRESS = 4'd1;
        DATA_IN = {12'd0, v};
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        DATA_IN = 16'd0;
        if (v[2]) m_ovr = 1'b0;
        if (v[3]) m_ferr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTb = 1'b0;
        RX = 1'b1;
        idle(3);
        RSTb = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        idle(2);
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] d;
        int         r;

        idle(5);
        RSTb = 1'b1;
        idle(2);
        check_status("reset");

        send(8'hA5, 1'b1, 1);
        check_status("single");
        pop_check("single_pop");
        check_status("single_after_rd");

        send(8'h77, 1'b1, 1);
        do_reset();
        check_status("reset_pending");

        @(negedge CLK);
        RX = 1'b0;
        idle(30);
        RX = 1'b1;
        idle(200);
        check_status("glitch");

        send(8'h3C, 1'b0, 3);
        idle(20);
        check_status("ferr");
        write_stat(4'h8);
        check_status("ferr_clr");

        for (int i = 1; i <= DEPTH + 1; i++) send(8'(i), 1'b1, 1);
        check_status("ovr");
        for (int i = 0; i < DEPTH; i++) pop_check("ovr_pop");
        check_status("ovr_drained");
        write_stat(4'h4);
        check_status("ovr_clr");

        // Reset during data bit 4 of a frame.
        frame = {1'b1, 8'hC3, 1'b0};
        drive_bits(frame, 5);
        RX = frame[5];
        idle(BIT_CYC / 2);
        do_reset();
        idle(2 * BIT_CYC);
        check_status("midframe_reset");
        send(8'h5A, 1'b1, 1);
        check_status("after_reset_frame");
        pop_check("after_reset_pop");

        for (int it = 0; it < 24; it++) begin
            r = int'($urandom_range(0, 5));
            d = 8'($urandom);
            if (r <= 2)      send(d, 1'b1, 1);
            else if (r == 3) send(d, 1'b0, int'($urandom_range(1, 3)));
            else if (r == 4) pop_check("rnd_pop");
            else             write_stat(4'($urandom) & 4'b1100);
            idle(int'($urandom_range(0, 40)));
            check_status("rnd");
        end
        while (q.size() != 0) pop_check("drain_pop");
        check_status("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Memory-mapped UART receive peripheral: the receive end of the existing 8N1 transmit peripheral, on the same CPU bus style. The block samples the serial `RX` line at the middle of each bit, assembles 8N1 frames LSB first and buffers received bytes. The CPU reads data and sticky status through the register interface. It sits on the peripheral bus next to the transmit peripheral and shares its parameters.

## Interface
Parameters:
- `CLK_FREQ`, 12000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `BITS`, 16, bus data width (minimum 8)
- `FIFO_DEPTH`, 8, receive FIFO entries; must be a power of two; used only when `UART_RX_FIFO_EN` is defined

Ports:
- `CLK` in 1, system clock; the block has one clock
- `RSTb` in 1, reset, asynchronous and active-low
- `ADDRESS` in 4, read register select
- `WR_ADDRESS` in 4, write register select
- `DATA_IN` in BITS, write data
- `DATA_OUT` out BITS, read data, combinational from `ADDRESS`
- `WR` in 1, write strobe
- `RD` in 1, read strobe; pops the buffer when `ADDRESS`=0
- `RX` in 1, serial input, asynchronous to `CLK`, idles high

## Operation
- **Derived constants**
  - `BIT_CYC` = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE; this is 104 at the defaults.
  - `HALF_CYC` = BIT_CYC/2.
- **Input synchroniser:** `RX` passes through a 2-flop synchroniser that resets to 1. All decisions use the synchronised value `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. The bit counter is 16 bits and restarts at 0 on every state entry and every sampled bit.
  - **IDLE:** `rx_s`=0 → START.
  - **START:** at count `HALF_CYC`-1, if `rx_s`=0 → DATA; if `rx_s`=1 the low pulse was a glitch → IDLE, and no status changes.
  - **DATA:** at count `BIT_CYC`-1, shift `rx_s` into bit [idx] (LSB first). After bit 7 → STOP.
  - **STOP:** at count `BIT_CYC`-1:
    - `rx_s`=1: push the byte → IDLE.
    - `rx_s`=0: set `FERR`, discard the byte → WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s`=1 → IDLE. A break condition therefore produces exactly one framing error.
- **Read registers** (`DATA_OUT`, upper unused bits are 0):
  - Address 0: bits [7:0] hold the buffer head; they read 0 when the buffer is empty.
  - Address 1, status:
    - bit0 `VALID` (buffer not empty)
    - bit1 `FULL`
    - bit2 `OVR`, sticky
    - bit3 `FERR`, sticky
  - All other addresses read 0.
- **Pop:** `RD`=1 with `ADDRESS`=0 pops at the clock edge. A pop on an empty buffer is ignored.
- **Write register:** `WR`=1 with `WR_ADDRESS`=1 clears `OVR` if `DATA_IN[2]`=1 and clears `FERR` if `DATA_IN[3]`=1 (write-1-to-clear). All other writes are ignored.
- **Push while full:** the byte is dropped and `OVR` is set. The buffer contents are unchanged.
- **Simultaneous push and pop:** the pop takes effect first. A push while full plus a pop in the same cycle is accepted, and no overrun is flagged.
- **Simultaneous set and clear:** if a sticky bit is set by the hardware and cleared by a write in the same cycle, the set wins.

## Timing
- **Reset:** asynchronous reset clears the FSM to IDLE, the counters, the buffer pointers/count and `OVR`/`FERR`. After reset, `DATA_OUT` reads 0 at every address.
- **Sample point:** data bits are sampled 1.5, 2.5, … 8.5 bit periods after the detected start edge, plus 2 cycles of synchroniser latency.
- **Byte latency:** the byte is written at the clock edge that samples the stop bit. `VALID` and the data are visible on `DATA_OUT` in the following cycle.
- **Read:** read data is valid in the same cycle as `RD`. The next entry appears on the cycle after the pop.
- **Reset mid-frame:** the partial byte is discarded. The next complete frame is received normally.

## Configuration
- `UART_RX_FIFO_EN` defined:
  - The buffer is a circular FIFO of `FIFO_DEPTH` entries, with wrap-around read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - `FULL` = (count == FIFO_DEPTH).
- `UART_RX_FIFO_EN` undefined:
  - The buffer is a single holding register plus a full flag, so the effective depth is 1.
  - `VALID` equals `FULL`. All other behaviour is identical.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum
  - register addresses (`UART_RX_DATA_ADDR`=0, `UART_RX_STAT_ADDR`=1)
  - status bit positions (`VALID`=0, `FULL`=1, `OVR`=2, `FERR`=3)
- **Sub-module `uart_rx_core`:** the synchroniser, bit counter and FSM. It outputs the byte, a 1-cycle `byte_stb` and a 1-cycle `ferr_stb`.
- **Top level:** holds the buffer, status flags and register decode.

## Test plan
1. **Reset state:** assert `RSTb`=0 mid-simulation, then release → status (`ADDRESS`=1) reads 0x0000 and address 0 reads 0x0000.
2. **Single byte:** drive 0xA5 as 8N1 at `BIT_CYC`=104 → one cycle after the stop sample, status=0x0001 and address 0 reads 0x00A5. After `RD`, status=0x0000.
3. **Start glitch:** hold `RX` low for 30 cycles → FSM returns to IDLE, and status stays 0x0000.
4. **Framing error:** send 0x3C with a low stop bit, held low for 3 bit periods → status=0x0008 with no data, and exactly one error. A write of 0x0008 to address 1 clears it to 0x0000.
5. **Overrun:** send DEPTH+1 bytes 0x01, 0x02, … without reading (9 bytes with the macro, 2 without) → status=0x0007. Reads return 0x01..DEPTH in order, and the last byte is lost.
6. **Reset mid-frame:** assert `RSTb` during data bit 4 of a frame → after release, status=0x0000, and a following 0x5A frame reads back as 0x005A.
